bin2bcd_digits: RTL
===================

// Module: bin2bcd_digits
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//  Feeds the four 5-bit {dp,nibble} digit inputs of seven_seg_controller so a
//  binary counter value can be shown in decimal rather than hex.
//  Sits between the counter/datapath and the display controller.
//  Output digits are registered and change only when a conversion completes.
// PARAMETERS
//  WIDTH  14  Bit width of the binary input. Legal range is 4..14.
// PORTS
//  clk      in   1      System clock. All state changes on the rising edge.
//  reset_n  in   1      Asynchronous, active-low reset.
//  value    in   WIDTH  Unsigned binary value to convert. Sampled on an accepted start.
//  start    in   1      Conversion request. Sampled only in IDLE.
//  dp_sel   in   4      Decimal-point bits for digits3..0. Sampled with value.
//  digits0  out  5      {dp_sel[0], ones BCD}.
//  digits1  out  5      {dp_sel[1], tens BCD}.
//  digits2  out  5      {dp_sel[2], hundreds BCD}.
//  digits3  out  5      {dp_sel[3], thousands BCD}.
//  busy     out  1      High while in SHIFT or DONE.
//  done     out  1      One-cycle pulse when digits0..3 update.
//  overflow out  1      Registered with the digits. 1 if the last converted value > 9999.
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; digits0..3=5'h00; busy=0; done=0;
//    overflow=0; internal shift register and bit counter cleared.
//  - FSM states: IDLE, SHIFT, DONE.
//  - IDLE: when start=1 at a clock edge:
//      load bin_sr<=value, bcd_sr(16b)<=0, cnt<=WIDTH, dp_q<=dp_sel, ovf_q<=(value>9999);
//      next state SHIFT.
//    When start=0, remain in IDLE.
//  - SHIFT, each cycle:
//      1. Every bcd nibble >=5 gets +3.
//      2. Shift {bcd_sr,bin_sr} left by 1.
//      3. cnt<=cnt-1.
//    After the WIDTH-th shift, next state is DONE.
//  - DONE, one cycle:
//      digitsN <= {dp_q[N], bcd_sr nibble N}, or {dp_q[N],4'hF} if ovf_q;
//      overflow<=ovf_q; done=1; next state IDLE.
//  - Latency: start sampled at edge 0; done=1 and new digits visible after edge WIDTH+1.
//    Default WIDTH=14 gives 15 cycles.
//    Back-to-back throughput is one conversion per WIDTH+2 cycles
//    (start may be accepted on the edge following done).
//  - start while busy=1 (SHIFT or DONE): ignored, not queued.
//    value and dp_sel changes during busy have no effect.
//  - Arithmetic: the add-3 check uses nibble>=5, 4-bit add with no carry out.
//    Values <=9999 therefore never produce a nibble >9.
//  - Overflow: with value>9999 the conversion still runs the full WIDTH cycles.
//    The displayed result is FFFF with the dp bits kept.
//  - Reset during SHIFT/DONE: the conversion is abandoned, outputs return to
//    reset values, and done never fires.
//  - Between conversions, digits0..3 and overflow hold their last values.
//  - WIDTH<14: value is zero-extended internally. Overflow is impossible when 2^WIDTH-1 <= 9999.
// TESTING
//  1. value=1234, dp_sel=0, start 1 cycle
//     -> done exactly 15 cycles later; digits3..0 = 01,02,03,04 (hex); overflow=0.
//  2. value=0, then value=9999, dp_sel=4'b1000
//     -> digits 00,00,00,00; then 19,09,09,09 (bit4 of digits3 set).
//  3. value=10000
//     -> digits 0F,0F,0F,0F; overflow=1.
//     A following value=42 gives 00,00,04,02 and clears overflow.
//  4. start=1 with value=1234, then start=1 held with value=5678 during busy
//     -> only 1234 is shown.
//     The next accepted start is at the edge after done, and 5678 appears 15 cycles later.
//  5. Assert reset_n=0 mid-SHIFT (cycle 7)
//     -> digits=00, busy=0 asynchronously; no done pulse.
//     A fresh start then converts correctly.
//  6. Random sweep of 0..16383 against a reference model
//     -> BCD correct for <=9999, FFFF plus overflow above; done always one cycle wide.

Source files
------------

// File: rtl/bin2bcd_digits.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Produces four {dp,nibble} digits for the seven-segment controller; FFFF on overflow.
module bin2bcd_digits #(
   parameter int WIDTH = 14
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] value,
   input  logic             start,
   input  logic [3:0]       dp_sel,
   output logic [4:0]       digits0,
   output logic [4:0]       digits1,
   output logic [4:0]       digits2,
   output logic [4:0]       digits3,
   output logic             busy,
   output logic             done,
   output logic             overflow
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam int CW = $clog2(WIDTH + 1);

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [WIDTH-1:0] bin_sr;
   logic [15:0]     bcd_sr, bcd_adj;
   logic [3:0]      dp_q;
   logic            ovf_q, ovf_in;
   logic [3:0][4:0] dig_q;

   // Zero-extend before the compare so narrow WIDTHs stay width-clean.
   assign ovf_in = ({{(32-WIDTH){1'b0}}, value} > 32'd9999);

   for (genvar n = 0; n < 4; n++) begin : g_adj
      assign bcd_adj[4*n +: 4] = (bcd_sr[4*n +: 4] >= 4'd5) ? bcd_sr[4*n +: 4] + 4'd3
                                                          : bcd_sr[4*n +: 4];
   end

   assign digits0 = dig_q[0];
   assign digits1 = dig_q[1];
   assign digits2 = dig_q[2];
   assign digits3 = dig_q[3];
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (cnt == CW'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         bin_sr   <= '0;
         bcd_sr   <= '0;
         dp_q     <= '0;
         ovf_q    <= 1'b0;
         dig_q    <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               bin_sr <= value;
               bcd_sr <= '0;
               cnt    <= CW'(WIDTH);
               dp_q   <= dp_sel;
               ovf_q  <= ovf_in;
            end
            SHIFT: begin
               // Add-3 correction first, then shift the MSB of the binary into the BCD.
               bcd_sr <= {bcd_adj[14:0], bin_sr[WIDTH-1]};
               bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
               cnt    <= cnt - 1'b1;
            end
            DONE: begin
               for (int n = 0; n < 4; n++)
                  dig_q[n] <= {dp_q[n], ovf_q ? 4'hF : bcd_sr[4*n +: 4]};
               overflow <= ovf_q;
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
